// File: rtl/sw_debounce_enable_pkg.sv
// Shared definitions for switch/button front-ends: debounce FSM encoding and counter sizing.
package sw_debounce_enable_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

    // Width able to hold 0..cycles inclusive; at least one bit.
    function automatic int db_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_enable_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; clears to 0 on synchronous active-low reset.
module sync_2ff (
    input  logic sysclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/sw_debounce_enable.sv
// Switch cleaner for the LED PWM breathing stage: synchroniser, consecutive-cycle debounce FSM,
// registered edge strobes and an enable that is either the debounced level or a press-to-toggle latch.
module sw_debounce_enable #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit TOGGLE_MODE     = 1'b0
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic SW_raw,
    output logic Enable_SW_1,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall
);

    import sw_debounce_enable_pkg::*;

    localparam int            CW       = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic          sw_sync;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          enable_q, enable_d;

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    sync_2ff u_sync (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .d      (SW_raw),
        .q      (sw_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (sw_sync) begin
                    // A one-cycle debounce window needs no wait state.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!sw_sync) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            IDLE_HI: begin
                if (!sw_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (sw_sync) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
        enable_d = TOGGLE_MODE ? (enable_q ^ rise_d) : level_d;
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            enable_q <= enable_d;
        end
    end

    assign Enable_SW_1 = enable_q;
    assign sw_level    = level_q;
    assign sw_rise     = rise_q;
    assign sw_fall     = fall_q;

endmodule

// File: tb/tb_sw_debounce_enable.sv
// Bench for sw_debounce_enable: level and toggle instances share stimulus; a run-length model feeds a scoreboard.
module tb_sw_debounce_enable;

    import sw_debounce_enable_pkg::*;

    localparam int D = 4;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic SW_raw = 1'b0;

    logic l_en, l_lvl, l_rise, l_fall;
    logic t_en, t_lvl, t_rise, t_fall;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    sw_debounce_enable #(.DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b0)) dut_l (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .SW_raw      (SW_raw),
        .Enable_SW_1 (l_en),
        .sw_level    (l_lvl),
        .sw_rise     (l_rise),
        .sw_fall     (l_fall)
    );

    sw_debounce_enable #(.DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b1)) dut_t (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .SW_raw      (SW_raw),
        .Enable_SW_1 (t_en),
        .sw_level    (t_lvl),
        .sw_rise     (t_rise),
        .sw_fall     (t_fall)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    endtask

    // Reference model: a change is accepted once D consecutive synchronised samples differ from the level.
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_tog = 1'b0;
    int         m_run = 0;
    bit         armed = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge sysclk) begin : model
        logic s1n, s2n, lvln, risen, falln, togn;
        int   runn;
        if (!rst_n) begin
            s1n = 1'b0; s2n = 1'b0; lvln = 1'b0; risen = 1'b0; falln = 1'b0; togn = 1'b0; runn = 0;
        end else begin
            s1n   = SW_raw;
            s2n   = m_s1;
            lvln  = m_lvl;
            togn  = m_tog;
            risen = 1'b0;
            falln = 1'b0;
            runn  = (m_s2 != m_lvl) ? m_run + 1 : 0;
            if (runn == D) begin
                runn = 0;
                lvln = ~m_lvl;
                if (lvln) begin
                    risen = 1'b1;
                    togn  = ~m_tog;
                end else begin
                    falln = 1'b1;
                end
            end
        end
        m_s1   <= s1n;
        m_s2   <= s2n;
        m_lvl  <= lvln;
        m_rise <= risen;
        m_fall <= falln;
        m_tog  <= togn;
        m_run  <= runn;
        if (armed || !rst_n)
            exp_q.push_back({togn, lvln, risen, falln, lvln, lvln, risen, falln});
        armed <= armed | !rst_n;
    end

    logic prev_lvl = 1'b0;

    always @(negedge sysclk) begin : monitor
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", {24'd0, t_en, t_lvl, t_rise, t_fall, l_en, l_lvl, l_rise, l_fall}, {24'd0, e});
            check("rise_and_fall", {31'd0, (l_rise & l_fall) | (t_rise & t_fall)}, 32'd0);
            check("xfree", {31'd0, $isunknown({t_en, t_lvl, t_rise, t_fall, l_en, l_lvl, l_rise, l_fall})}, 32'd0);
            check("lvl_without_strobe", {31'd0, (l_lvl != prev_lvl) && !(l_rise | l_fall)}, 32'd0);
            prev_lvl <= l_lvl;
        end
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic wait_strobe(input bit fall_sel, output int at, output logic en_l, output logic en_t);
        at   = -1;
        en_l = 1'bx;
        en_t = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (fall_sel ? l_fall : l_rise) begin
                at   = cyc;
                en_l = l_en;
                en_t = t_en;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   k0, at, nstrobe;
        logic el, et;
        bit   found;

        // Reset held three cycles while the switch bounces.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", {27'd0, l_en, l_lvl, l_rise, l_fall, t_en}, 32'd0);
            SW_raw = ~SW_raw;
        end
        SW_raw = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("state_after_rst", 32'(dut_l.state_q), 32'(IDLE_LO));
        repeat (3) tick();

        // Clean press: rise D+1 cycles after the first sample.
        SW_raw = 1'b1;
        k0 = cyc + 1;
        wait_strobe(1'b0, at, el, et);
        check("rise_latency", at, k0 + D + 1);
        check("en_level_at_rise", {31'd0, el}, 32'd1);
        tick();
        check("rise_one_cycle", {31'd0, l_rise}, 32'd0);
        check("en_level_hold", {31'd0, l_en}, 32'd1);
        SW_raw = 1'b0;
        k0 = cyc + 1;
        wait_strobe(1'b1, at, el, et);
        check("fall_latency", at, k0 + D + 1);
        check("en_level_at_fall", {31'd0, el}, 32'd0);
        repeat (3) tick();

        // Bounce: 3 high / 2 low repeated, then a steady hold.
        nstrobe = 0;
        for (int r = 0; r < 5; r++) begin
            SW_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                nstrobe += int'(l_rise | l_fall);
            end
            SW_raw = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                nstrobe += int'(l_rise | l_fall);
            end
        end
        check("bounce_strobes", nstrobe, 0);
        check("bounce_level", {31'd0, l_lvl}, 32'd0);
        SW_raw = 1'b1;
        k0 = cyc + 1;
        wait_strobe(1'b0, at, el, et);
        check("rise_after_bounce", at, k0 + D + 1);
        SW_raw = 1'b0;
        wait_strobe(1'b1, at, el, et);
        check("fall_after_bounce_seen", {31'd0, at > 0}, 32'd1);
        repeat (3) tick();

        // Toggle mode from a fresh reset: three press/release cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            SW_raw = 1'b1;
            wait_strobe(1'b0, at, el, et);
            check("toggle_on_rise", {31'd0, et}, (i % 2 == 0) ? 32'd1 : 32'd0);
            repeat (2) tick();
            SW_raw = 1'b0;
            wait_strobe(1'b1, at, el, et);
            check("toggle_hold_on_fall", {31'd0, et}, (i % 2 == 0) ? 32'd1 : 32'd0);
            repeat (2) tick();
        end

        // Reset mid-debounce discards the count; switch still high at release.
        SW_raw = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut_l.state_q == WAIT_HI && int'(dut_l.cnt_q) == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_wait_hi_cnt2", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_state", 32'(dut_l.state_q), 32'(IDLE_LO));
        check("rst_mid_cnt", 32'(dut_l.cnt_q), 32'd0);
        check("rst_mid_no_strobe", {31'd0, l_rise | l_fall}, 32'd0);
        rst_n = 1'b1;
        k0 = cyc + 1;
        wait_strobe(1'b0, at, el, et);
        check("rise_after_rst_release", at, k0 + D + 1);
        check("toggle_after_rst_release", {31'd0, et}, 32'd1);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
